// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: upstream and downstream valid/ready channels of the
// immediate generator.
//   in_valid_i / in_ready_o / instr_i / tag_i     : instruction from fetch
//   out_valid_o / out_ready_i / imm_o / fmt_o /
//   illegal_o / tag_o                             : decoded result to register read
// The master modport is the side that feeds instructions and takes results.
// The slave modport is the generator itself.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  imm_o;
  logic [2:0]       fmt_o;
  logic             illegal_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid_i, instr_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
  );

  modport slave (
    input  in_valid_i, instr_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator with the CSR zimm.
// It decodes instr_i combinationally. The result (immediate, format,
// illegal flag and tag) is registered into an output stage that is backed
// by one skid entry, so in_ready_o depends only on a flop.
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   flush_i        synchronous flush that drops both entries
//   io             imm_gen_pipe_if slave (upstream and downstream handshakes)
//   illegal_cnt_o  saturating count of illegal results delivered downstream
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 32,
  parameter int EN_ZICSR = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  imm_gen_pipe_if.slave    io,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_CSR   = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           dec;
  entry_t           out_q;
  entry_t           skid_q;
  logic             out_valid_q;
  logic             skid_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      instr;
  logic             accept;
  logic             consume;

  assign instr = io.instr_i;

  // Sign-extended formats fill the word with instr[31] first and then
  // overwrite the low field. This works for either XLEN and needs no
  // zero-width replication.
  always_comb begin
    dec     = '0;
    dec.tag = io.tag_i;
    case (instr[6:0])
      OPC_OP_IMM, OPC_OP_IMM32: begin
        if (instr[6:0] == OPC_OP_IMM32 && XLEN != 64) begin
          dec.ill = 1'b1;
        end else if (instr[13:12] == 2'b01) begin
          dec.fmt = FMT_SHAMT;
          if (XLEN == 64 && instr[6:0] == OPC_OP_IMM) dec.imm[5:0] = instr[25:20];
          else                                        dec.imm[4:0] = instr[24:20];
        end else begin
          dec.fmt       = FMT_I;
          dec.imm       = {XLEN{instr[31]}};
          dec.imm[11:0] = instr[31:20];
        end
      end
      OPC_LOAD, OPC_JALR: begin
        dec.fmt       = FMT_I;
        dec.imm       = {XLEN{instr[31]}};
        dec.imm[11:0] = instr[31:20];
      end
      OPC_STORE: begin
        dec.fmt       = FMT_S;
        dec.imm       = {XLEN{instr[31]}};
        dec.imm[11:0] = {instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        dec.fmt       = FMT_B;
        dec.imm       = {XLEN{instr[31]}};
        dec.imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.fmt       = FMT_U;
        dec.imm       = {XLEN{instr[31]}};
        dec.imm[31:0] = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec.fmt       = FMT_J;
        dec.imm       = {XLEN{instr[31]}};
        dec.imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        if (EN_ZICSR != 0) begin
          dec.fmt = FMT_CSR;
          if (instr[14]) dec.imm[4:0] = instr[19:15];
        end else begin
          dec.ill = 1'b1;
        end
      end
      default: dec.ill = 1'b1;
    endcase
  end

  assign accept  = io.in_valid_i & ~skid_valid_q;
  assign consume = out_valid_q & io.out_ready_i;

  // The skid entry fills only while the output stage is stalled. Once it is
  // full, in_ready_o is low, so a draining output takes the skid entry and
  // never takes a new instruction in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (consume && out_q.ill && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      if (flush_i) begin
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (out_valid_q && !io.out_ready_i) begin
        if (accept) begin
          skid_q       <= dec;
          skid_valid_q <= 1'b1;
        end
      end else if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign io.in_ready_o  = ~skid_valid_q;
  assign io.out_valid_o = out_valid_q;
  assign io.imm_o       = out_q.imm;
  assign io.fmt_o       = out_q.fmt;
  assign io.illegal_o   = out_q.ill;
  assign io.tag_o       = out_q.tag;
  assign illegal_cnt_o  = cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage. It decodes every RV32I/RV64I immediate format, plus the CSR zimm. It flags unsupported opcodes and sits between fetch and the register-read stage. Both sides use valid/ready handshakes, and a 2-entry skid buffer gives full throughput under backpressure. A saturating counter records how many illegal instructions have been delivered downstream.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag (normally the PC), passed through unchanged.
EN_ZICSR, 1, when 1 the SYSTEM opcode decodes CSR zimm; when 0 SYSTEM is illegal.
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  synchronous pipeline flush
in_valid_i  in  1  upstream instruction valid
in_ready_o  out  1  block can accept an instruction
instr_i  in  32  instruction word
tag_i  in  TAG_W  sideband tag
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts the result
imm_o  out  XLEN  extended immediate
fmt_o  out  3  format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR
illegal_o  out  1  opcode not supported
tag_o  out  TAG_W  tag associated with imm_o
illegal_cnt_o  out  CNT_W  count of illegal instructions delivered

Behaviour:
- Reset (rst_n low, asynchronous): out_valid_o=0, in_ready_o=1, imm_o=0, fmt_o=0, illegal_o=0, tag_o=0, illegal_cnt_o=0, skid buffer empty.
- Decode is combinational on instr_i. "sx" means sign extension from instr[31] to XLEN.
  - OP-IMM 0010011, funct3 001/101: fmt SHAMT; imm = zero-extended instr[24:20] if XLEN=32, instr[25:20] if XLEN=64.
  - OP-IMM, other funct3: fmt I; imm = sx instr[31:20].
  - LOAD 0000011 and JALR 1100111: fmt I; imm = sx instr[31:20].
  - OP-IMM-32 0011011: legal only when XLEN=64; same rules as OP-IMM, but shamt is always instr[24:20].
  - STORE 0100011: fmt S; imm = sx {instr[31:25], instr[11:7]}.
  - BRANCH 1100011: fmt B; imm = sx {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - LUI 0110111 and AUIPC 0010111: fmt U; imm = sx {instr[31:12], 12'b0}. For XLEN=64 bits 63:32 replicate bit 31.
  - JAL 1101111: fmt J; imm = sx {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - SYSTEM 1110011 with EN_ZICSR=1: fmt CSR. funct3[2]=1 gives imm = zero-extended instr[19:15]; otherwise imm=0.
  - Any other opcode: fmt 0, imm=0, illegal=1.
- Handshake:
  - Input is accepted when in_valid_i & in_ready_o. Output is consumed when out_valid_o & out_ready_i.
  - Latency is 1 cycle: a result accepted at edge N is visible after edge N.
  - in_ready_o = !skid_valid and is a registered signal; there is no combinational path from out_ready_i.
  - With the output register full and out_ready_i=0, an accepted instruction goes to the skid entry and in_ready_o falls on the next cycle.
  - When the output drains and the skid is full, the skid entry moves to the output register.
  - Strict FIFO order; no drops, no duplicates.
  - Output data is stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous input accept and output consume: full throughput, one result per cycle, skid stays empty.
- flush_i (synchronous, highest priority):
  - At the edge, both entries are invalidated and in_valid_i is ignored.
  - Next cycle: out_valid_o=0, in_ready_o=1.
  - illegal_cnt_o is not cleared; an output handshake in the flush cycle still counts.
- illegal_cnt_o increments on each output handshake with illegal_o=1 and saturates at 2^CNT_W-1.
- Reset mid-operation: all state returns immediately to the reset values.

Test Plan:
- ADDI 0xFFF00093, out_ready=1 -> after 1 cycle: imm_o=0xFFFFFFFF, fmt_o=1, illegal_o=0, tag_o matches tag_i.
- BEQ x0,x0,-4 (0xFE000EE3) -> imm_o=0xFFFFFFFC, fmt_o=3. SRAI 0x4050D093 -> imm_o=5, fmt_o=6. LUI 0x123450B7 -> imm_o=0x12345000, fmt_o=4.
- XLEN=64: LUI 0x800000B7 -> imm_o=0xFFFFFFFF80000000. SLLI with shamt 40 -> imm_o=40. OP-IMM-32 legal. Same OP-IMM-32 word with XLEN=32 -> illegal_o=1.
- Backpressure: out_ready=0, present tags A,B,C back to back.
  - A lands in output, B in skid; in_ready_o drops; C is held upstream.
  - Raise out_ready -> A, B, C delivered in order on consecutive cycles, none lost.
- Flush with output and skid both full -> next cycle out_valid_o=0, in_ready_o=1; the next instruction emerges 1 cycle after acceptance.
- CNT_W=2: deliver 5 instructions with opcode 0x7F -> each has illegal_o=1, imm_o=0, fmt_o=0. illegal_cnt_o reads 1,2,3,3,3. Assert rst_n low mid-stream -> all outputs return to 0 immediately.
